// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern and don't-care mask.
// Registered one-cycle match pulse and saturating match counter.
module seq_pattern_detector #(
    parameter int unsigned    LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b110,
    parameter bit             OVERLAP = 1'b1,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_in,
    input  logic [LEN-1:0]   mask_in,
    input  logic             clr_cnt,
    output logic             w,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned    FW   = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(LEN);
    localparam logic [FW-1:0]  ARM  = FW'(LEN - 1);

    logic [LEN-1:0]   hist_q, hist_d;
    logic [LEN-1:0]   pat_q, pat_d;
    logic [LEN-1:0]   mask_q, mask_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN-1:0]   nxt;
    logic             armed;
    logic             hit;

    assign nxt   = {hist_q[LEN-2:0], a};
    assign armed = (fill_q >= ARM);
    // A load cycle never samples a, so it can never produce a hit.
    assign hit   = en && !pat_load && armed &&
                   (((nxt ^ pat_q) & mask_q) == '0);

    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        mask_d = mask_q;
        fill_d = fill_q;
        w_d    = 1'b0;
        cnt_d  = cnt_q;
        if (pat_load) begin
            pat_d  = pat_in;
            mask_d = mask_in;
            fill_d = '0;
        end else if (en) begin
            hist_d = nxt;
            w_d    = hit;
            fill_d = (fill_q == FULL) ? FULL : fill_q + FW'(1);
            if (hit && !OVERLAP) begin
                fill_d = '0;
            end
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            pat_q  <= PATTERN;
            mask_q <= '1;
            fill_q <= '0;
            w_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            mask_q <= mask_d;
            fill_q <= fill_d;
            w_q    <= w_d;
            cnt_q  <= cnt_d;
        end
    end

    assign w         = w_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: three instances with shared stimulus,
// expected outputs queued per step and checked by an independent monitor.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       a = 1'b0;
    logic       ld = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] pat = '0;
    logic [3:0] msk = '0;

    logic       w0, w1, w2;
    logic [7:0] c0;
    logic [1:0] c1;
    logic [7:0] c2;

    int checks = 0;
    int failures = 0;
    int step_no = 0;

    typedef struct {
        logic [2:0] chk;
        logic [2:0] ew;
        int         e0;
        int         e1;
        int         e2;
        int         id;
    } exp_t;

    exp_t q[$];
    exp_t m;

    always #5 clk = ~clk;

    // u0: default detector110-compatible configuration
    seq_pattern_detector u0 (
        .clk(clk), .reset(rst_n), .en(en), .a(a), .pat_load(ld),
        .pat_in(pat[2:0]), .mask_in(msk[2:0]), .clr_cnt(clr),
        .w(w0), .match_cnt(c0)
    );

    seq_pattern_detector #(
        .LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2)
    ) u1 (
        .clk(clk), .reset(rst_n), .en(en), .a(a), .pat_load(ld),
        .pat_in(pat), .mask_in(msk), .clr_cnt(clr),
        .w(w1), .match_cnt(c1)
    );

    seq_pattern_detector #(
        .LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)
    ) u2 (
        .clk(clk), .reset(rst_n), .en(en), .a(a), .pat_load(ld),
        .pat_in(pat), .mask_in(msk), .clr_cnt(clr),
        .w(w2), .match_cnt(c2)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic step(input bit e, input bit av, input bit l, input bit c,
                        input logic [2:0] chk, input logic [2:0] ew,
                        input int e0, input int e1, input int e2);
        exp_t x;
        @(negedge clk);
        en  = e;
        a   = av;
        ld  = l;
        clr = c;
        x.chk = chk;
        x.ew  = ew;
        x.e0  = e0;
        x.e1  = e1;
        x.e2  = e2;
        x.id  = step_no;
        step_no++;
        q.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                m = q.pop_front();
                if (m.chk[0]) begin
                    check($sformatf("s%0d_u0_w", m.id), int'(w0), int'(m.ew[0]));
                    check($sformatf("s%0d_u0_cnt", m.id), int'(c0), m.e0);
                end
                if (m.chk[1]) begin
                    check($sformatf("s%0d_u1_w", m.id), int'(w1), int'(m.ew[1]));
                    check($sformatf("s%0d_u1_cnt", m.id), int'(c1), m.e1);
                end
                if (m.chk[2]) begin
                    check($sformatf("s%0d_u2_w", m.id), int'(w2), int'(m.ew[2]));
                    check($sformatf("s%0d_u2_cnt", m.id), int'(c2), m.e2);
                end
            end
        end
    end

    int t2a[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
    int t2w1[8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    int t2c1[8] = '{0, 0, 0, 1, 1, 2, 2, 3};
    int t2w2[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int t2c2[8] = '{0, 0, 0, 1, 1, 1, 1, 2};
    int t5w[12] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int t5c[12] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_u0_w", int'(w0), 0);
        check("rst_u0_cnt", int'(c0), 0);
        check("rst_u1_w", int'(w1), 0);
        check("rst_u1_cnt", int'(c1), 0);
        check("rst_u2_w", int'(w2), 0);
        check("rst_u2_cnt", int'(c2), 0);
        #2 rst_n = 1'b1;

        // test 1: 1,1,1,0 on default 110
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b001, 1, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b000, 1, 0, 0);

        // test 2: 1010 overlapping (u1) and non-overlapping (u2)
        pat = 4'b1010;
        msk = 4'b1111;
        step(0, 0, 1, 1, 3'b110, 3'b000, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, t2a[i] != 0, 0, 0, 3'b110,
                 {t2w2[i] != 0, t2w1[i] != 0, 1'b0}, 0, t2c1[i], t2c2[i]);
        end

        // test 3: pattern 110 with middle bit don't-care
        pat = 4'b0110;
        msk = 4'b0101;
        step(0, 0, 1, 1, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b001, 1, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 1, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 1, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b001, 2, 0, 0);
        step(0, 0, 1, 0, 3'b001, 3'b000, 2, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b000, 2, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 2, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b000, 2, 0, 0);

        // test 4: enable gaps hold history
        pat = 4'b0110;
        msk = 4'b0111;
        step(0, 0, 1, 1, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(0, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(0, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b001, 1, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b000, 1, 0, 0);

        // test 5: 2-bit counter saturation, clear coincident with a match
        pat = 4'b1010;
        msk = 4'b1111;
        step(0, 0, 1, 1, 3'b010, 3'b000, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, (i % 2) == 0, 0, 0, 3'b010,
                 {1'b0, t5w[i] != 0, 1'b0}, 0, t5c[i], 0);
        end
        step(1, 1, 0, 0, 3'b010, 3'b000, 0, 3, 0);
        step(1, 0, 0, 1, 3'b010, 3'b010, 0, 0, 0);
        step(0, 0, 0, 0, 3'b010, 3'b000, 0, 0, 0);

        // test 6: async reset mid-sequence
        pat = 4'b0110;
        msk = 4'b0111;
        step(0, 0, 1, 1, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b001, 1, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 1, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 1, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_u0_w", int'(w0), 0);
        check("async_rst_u0_cnt", int'(c0), 0);
        #1 rst_n = 1'b1;
        step(1, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b001, 1, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b000, 1, 0, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
